// File: rtl/mul_seq_pkg.sv
// +--------------------------------------------------------------------+
// | mul_seq_pkg : shared types and constants for the shift-add multiplier |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package mul_seq_pkg;

  localparam int unsigned C_WIDTH_DEFAULT = 32;
  localparam int unsigned C_PROD_W        = 64;
  localparam int unsigned C_CNT_W         = $clog2(C_WIDTH_DEFAULT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mul_seq_datapath.sv
// +--------------------------------------------------------------------+
// | mul_seq_datapath : shift-add registers, 64-bit adder, iteration cnt  |
// | Option: MUL_SEQ_EARLY_TERM_EN ends the run once the multiplier is 0. |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module mul_seq_datapath
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = C_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                step,
  input  logic [C_PROD_W-1:0] a,
  input  logic [C_PROD_W-1:0] b,
  output logic [C_PROD_W-1:0] acc_next,
  output logic                last
);

  localparam int unsigned C_DP_CNT_W = $clog2(WIDTH + 1);

  logic [C_PROD_W-1:0]   r_mcand;
  logic [WIDTH-1:0]      r_mplr;
  logic [C_PROD_W-1:0]   r_acc;
  logic [C_DP_CNT_W-1:0] r_cnt;

  logic [C_PROD_W-1:0]   w_mcand_init;
  logic [WIDTH-1:0]      w_mplr_shift;
  logic [C_DP_CNT_W-1:0] w_cnt_next;

  // Operand bits above WIDTH are deliberately ignored.
  generate
    if (WIDTH < C_PROD_W) begin : g_ext
      logic w_unused_hi;
      assign w_mcand_init = {{(C_PROD_W-WIDTH){1'b0}}, a[WIDTH-1:0]};
      assign w_unused_hi  = ^{a[C_PROD_W-1:WIDTH], b[C_PROD_W-1:WIDTH]};
    end else begin : g_full
      assign w_mcand_init = a;
    end
  endgenerate

  assign acc_next     = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplr_shift = r_mplr >> 1;
  assign w_cnt_next   = r_cnt + C_DP_CNT_W'(1);

`ifdef MUL_SEQ_EARLY_TERM_EN
  assign last = (w_cnt_next == C_DP_CNT_W'(WIDTH)) || (w_mplr_shift == '0);
`else
  assign last = (w_cnt_next == C_DP_CNT_W'(WIDTH));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (load) begin
      r_mcand <= w_mcand_init;
      r_mplr  <= b[WIDTH-1:0];
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (step) begin
      r_mcand <= r_mcand << 1;
      r_mplr  <= w_mplr_shift;
      r_acc   <= acc_next;
      r_cnt   <= w_cnt_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_sequencer.sv
// +--------------------------------------------------------------------+
// | mul_sequencer : sequential shift-add unsigned multiplier (FSM+outs)  |
// | Option: MUL_SEQ_EARLY_TERM_EN (early completion, see datapath).      |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = C_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [C_PROD_W-1:0] a,
  input  logic [C_PROD_W-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [C_PROD_W-1:0] product
);

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [C_PROD_W-1:0] r_product;

  logic                w_load;
  logic                w_step;
  logic [C_PROD_W-1:0] w_acc_next;
  logic                w_last;

  assign w_load = (r_state == S_IDLE) && start;
  assign w_step = (r_state == S_RUN);

  mul_seq_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .step     (w_step),
    .a        (a),
    .b        (b),
    .acc_next (w_acc_next),
    .last     (w_last)
  );

  // The product captures the post-add accumulator of the final iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_product <= w_acc_next;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

`default_nettype wire

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; the product is 2*WIDTH bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 a  input  64  multiplicand; only a[WIDTH-1:0] is used.
REQ-006 b  input  64  multiplier; only b[WIDTH-1:0] is used.
REQ-007 busy  output  1  high in RUN and DONE.
REQ-008 done  output  1  one-cycle pulse; product is valid.
REQ-009 product  output  64  registered unsigned product, zero-extended to 64 bits.

Function
REQ-010 The FSM SHALL have three states, IDLE, RUN and DONE, with these transitions: IDLE->RUN on start; RUN->DONE on completion; DONE->IDLE unconditionally.
REQ-011 On the start-accept edge the block SHALL capture: mcand = zero-extended a[WIDTH-1:0]; mplr = b[WIDTH-1:0]; acc = 0; cnt = 0.
REQ-012 Each RUN cycle SHALL perform one iteration: if mplr[0], acc += mcand; then mcand <<= 1, mplr >>= 1, cnt += 1.
REQ-013 The adder SHALL be 64 bits wide; for unsigned operands overflow is impossible.
REQ-014 Completion SHALL occur on the RUN edge where cnt reaches WIDTH; on that edge product <= final acc and the state becomes DONE.
REQ-015 Latency: if start is sampled at edge k, done SHALL be high from edge k+WIDTH to edge k+WIDTH+1. With WIDTH=32 this is a 33-cycle start-to-done-sampled latency.
REQ-016 done SHALL be high only in DONE, for exactly one cycle per accepted start.
REQ-017 product SHALL change only on the completion edge and SHALL hold its value until the next completion.
REQ-018 start SHALL be ignored while in RUN or DONE: no queuing, no restart, no effect on the operation in progress.
REQ-019 start held high continuously SHALL be accepted again in the IDLE cycle after DONE, giving back-to-back operations with one idle cycle between them.
REQ-020 Changes on a or b after the accept edge SHALL NOT affect the result.

Reset
REQ-021 When rst_n is low the block SHALL immediately (asynchronously) return to IDLE with busy=0, done=0, product=0, and mcand, mplr, acc and cnt all 0.
REQ-022 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL be produced for the aborted operation.
REQ-023 After rst_n deasserts, the first rising edge with start high SHALL be accepted normally.

Configuration
REQ-024 The macro MUL_SEQ_EARLY_TERM_EN SHALL select the completion rule.
- Defined: completion SHALL also occur on any RUN edge where the post-shift mplr equals 0, so latency is 1 + (index of the highest set bit of b[WIDTH-1:0]) RUN cycles.
- Defined, b[WIDTH-1:0] = 0: exactly one RUN cycle, product = 0.
- Undefined: always WIDTH RUN cycles, per REQ-014.
REQ-025 Product values SHALL be identical with and without the macro; only latency differs.

Structure
REQ-026 A shared package mul_seq_pkg SHALL hold:
- the state typedef (IDLE/RUN/DONE);
- the WIDTH default;
- the product width constant;
- the counter width constant, $clog2(WIDTH+1).
REQ-027 A sub-module mul_seq_datapath SHALL contain the mcand, mplr, acc and cnt registers and the 64-bit adder, controlled by load/step strobes.
REQ-028 mul_sequencer SHALL contain the FSM and the product/done output registers.

Verification
REQ-029 a=3, b=5, start at edge k (macro undefined) -> done high at edge k+32, product=15, busy low after edge k+33.
REQ-030 a=0x00000000FFFFFFFF, b=0x00000000FFFFFFFF -> product=0xFFFFFFFE00000001.
REQ-031 a=0x0000000100000002, b=0xFFFFFFFF00000004 -> product=8 (upper operand bits ignored).
REQ-032 Start a=2, b=3; pulse start with a=7, b=7 at edge k+10 -> a single done pulse with product=6, no second done; a new start is accepted only after DONE.
REQ-033 Start a=9, b=9; drop rst_n at edge k+5 -> busy, done and product go to 0 immediately; no done follows; a fresh start of a=4, b=4 after release -> product=16.
REQ-034 With MUL_SEQ_EARLY_TERM_EN: a=6, b=1 -> done at edge k+1, product=6; a=6, b=0 -> done at edge k+1, product=0; a=6, b=0x80000000 -> done at edge k+32, product=0x0000000300000000.
